// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: register map, status bit
// positions and the ingress handshake state type.
package uart_pkg;

  localparam logic [2:0] UART_REG_STATUS = 3'd0;
  localparam logic [2:0] UART_REG_DATA   = 3'd1;
  localparam logic [2:0] UART_REG_COUNT  = 3'd2;

  localparam int unsigned STAT_AVAIL   = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_OVERRUN = 2;
  localparam int unsigned STAT_IRQ_EN  = 7;

  typedef enum logic {
    IDLE,
    WAIT_LOW
  } rxState_t;

endpackage

// File: rtl/sync_fifo.sv
// Byte FIFO of 2^DEPTH_LOG2 entries with occupancy count.
// A push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [7:0]            wrData,
  input  logic                  pop,
  output logic [7:0]            rdData,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam logic [DEPTH_LOG2:0] DEPTH = (DEPTH_LOG2+1)'(1) << DEPTH_LOG2;

  logic [7:0]            mem [0:(1 << DEPTH_LOG2) - 1];
  logic [DEPTH_LOG2-1:0] wrPtrQ;
  logic [DEPTH_LOG2-1:0] rdPtrQ;
  logic [DEPTH_LOG2:0]   countQ;
  logic                  doPush;
  logic                  doPop;

  assign full   = (countQ == DEPTH);
  assign empty  = (countQ == '0);
  assign count  = countQ;
  assign rdData = mem[rdPtrQ];

  assign doPop  = pop & ~empty;
  assign doPush = push & (~full | doPop);

  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtrQ] <= wrData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
    end else begin
      if (doPush) begin
        wrPtrQ <= wrPtrQ + (DEPTH_LOG2)'(1);
      end
      if (doPop) begin
        rdPtrQ <= rdPtrQ + (DEPTH_LOG2)'(1);
      end
      if (doPush && !doPop) begin
        countQ <= countQ + (DEPTH_LOG2+1)'(1);
      end else if (doPop && !doPush) begin
        countQ <= countQ - (DEPTH_LOG2+1)'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: handshake ingress into a FIFO, CPU register interface.
// Define UART_RX_FIFO_IRQ_EN to add the interrupt enable bit and irq output.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ack,
  input  logic       CS,
  input  logic [2:0] addr,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       WE
`ifdef UART_RX_FIFO_IRQ_EN
  ,
  output logic       irq
`endif
);

  rxState_t            stateQ, stateD;
  logic                ackQ, ackD;
  logic                rdSelQ;
  logic                overrunQ;
  logic                overrunSet;
  logic                overrunClr;
  logic [7:0]          doQ;
  logic [7:0]          rdMux;
  logic [7:0]          statusByte;
  logic                rdSel;
  logic                pop;
  logic                push;
  logic                full;
  logic                empty;
  logic [7:0]          headData;
  logic [DEPTH_LOG2:0] count;
  logic                irqEn;

  sync_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) uFifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .wrData (rx_data),
    .pop    (pop),
    .rdData (headData),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

  // Pop only on the rising edge of the read strobe so a stretched read pops once.
  assign rdSel      = CS & ~WE & (addr == UART_REG_DATA);
  assign pop        = rdSel & ~rdSelQ & ~empty;
  assign overrunClr = CS & WE & (addr == UART_REG_STATUS) & DI[STAT_OVERRUN];

  assign rx_ack = ackQ;
  assign DO     = doQ;

  always_comb begin
    stateD     = stateQ;
    ackD       = 1'b0;
    push       = 1'b0;
    overrunSet = 1'b0;
    unique case (stateQ)
      IDLE: begin
        if (rx_valid) begin
          ackD   = 1'b1;
          stateD = WAIT_LOW;
          if (!full || pop) begin
            push = 1'b1;
          end else begin
            overrunSet = 1'b1;
          end
        end
      end
      WAIT_LOW: begin
        if (!rx_valid) begin
          stateD = IDLE;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  always_comb begin
    statusByte               = 8'h00;
    statusByte[STAT_AVAIL]   = ~empty;
    statusByte[STAT_FULL]    = full;
    statusByte[STAT_OVERRUN] = overrunQ;
    statusByte[STAT_IRQ_EN]  = irqEn;
  end

  always_comb begin
    rdMux = 8'h00;
    case (addr)
      UART_REG_STATUS: rdMux = statusByte;
      UART_REG_DATA:   rdMux = empty ? 8'h00 : headData;
      UART_REG_COUNT:  rdMux = 8'(count);
      default:         rdMux = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ   <= IDLE;
      ackQ     <= 1'b0;
      rdSelQ   <= 1'b0;
      overrunQ <= 1'b0;
      doQ      <= 8'h00;
    end else begin
      stateQ   <= stateD;
      ackQ     <= ackD;
      rdSelQ   <= rdSel;
      // A new overrun wins over a same-cycle clear.
      overrunQ <= overrunSet | (overrunQ & ~overrunClr);
      if (CS && !WE) begin
        doQ <= rdMux;
      end
    end
  end

`ifdef UART_RX_FIFO_IRQ_EN
  logic irqEnQ;
  logic irqQ;
  logic unusedDi;

  assign irqEn    = irqEnQ;
  assign irq      = irqQ;
  assign unusedDi = ^{DI[6:3], DI[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irqEnQ <= 1'b0;
      irqQ   <= 1'b0;
    end else begin
      if (CS && WE && (addr == UART_REG_STATUS)) begin
        irqEnQ <= DI[STAT_IRQ_EN];
      end
      irqQ <= irqEnQ & (~empty | overrunQ);
    end
  end
`else
  logic unusedDi;

  assign irqEn    = 1'b0;
  assign unusedDi = ^{DI[7:3], DI[1:0]};
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (16-entry default build).
// Exercises the irq path too when UART_RX_FIFO_IRQ_EN is defined.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       CS;
  logic [2:0] addr;
  logic [7:0] DI;
  logic [7:0] DO;
  logic       WE;
`ifdef UART_RX_FIFO_IRQ_EN
  logic       irq;
`endif

  int compared   = 0;
  int mismatched = 0;

  uart_rx_fifo #(
    .DEPTH_LOG2(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ack   (rx_ack),
    .CS       (CS),
    .addr     (addr),
    .DI       (DI),
    .DO       (DO),
    .WE       (WE)
`ifdef UART_RX_FIFO_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // All drivers change inputs 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic busRead(input logic [2:0] a, output logic [7:0] d);
    CS   = 1'b1;
    WE   = 1'b0;
    addr = a;
    tick();
    CS   = 1'b0;
    d    = DO;
    tick();
  endtask

  task automatic busWrite(input logic [2:0] a, input logic [7:0] d);
    CS   = 1'b1;
    WE   = 1'b1;
    addr = a;
    DI   = d;
    tick();
    CS   = 1'b0;
    WE   = 1'b0;
    DI   = 8'h00;
  endtask

  task automatic sendByte(input logic [7:0] b, input int hold, output int acks);
    acks     = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (rx_ack) acks++;
    end
    rx_valid = 1'b0;
    tick();
    if (rx_ack) acks++;
  endtask

  initial begin
    logic [7:0] rd;
    int         acks;

    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    CS       = 1'b0;
    addr     = 3'd0;
    DI       = 8'h00;
    WE       = 1'b0;
    repeat (3) tick();
    check("reset_DO", DO, 8'h00);
    check("reset_ack", {7'd0, rx_ack}, 8'h00);
    rst_n = 1'b1;
    tick();

    busRead(3'd0, rd); check("reset_status", rd, 8'h00);
    busRead(3'd1, rd); check("reset_data", rd, 8'h00);
    busRead(3'd2, rd); check("reset_count", rd, 8'h00);
    busRead(3'd5, rd); check("unmapped_addr", rd, 8'h00);
    check("idle_ack", {7'd0, rx_ack}, 8'h00);

    // One byte with rx_valid held for 10 cycles.
    sendByte(8'h41, 10, acks);
    check("single_ack_count", 8'(acks), 8'd1);
    busRead(3'd0, rd); check("one_status", rd, 8'h01);
    busRead(3'd2, rd); check("one_count", rd, 8'h01);
    busRead(3'd1, rd); check("one_data", rd, 8'h41);
    busRead(3'd0, rd); check("one_status_after", rd, 8'h00);

    // Overfill with 17 bytes; the last is dropped.
    for (int i = 0; i < 17; i++) begin
      sendByte(8'(i), 2, acks);
      check("burst_ack", 8'(acks), 8'd1);
    end
    busRead(3'd2, rd); check("full_count", rd, 8'h10);
    busRead(3'd0, rd); check("full_status", rd, 8'h07);
    for (int i = 0; i < 16; i++) begin
      busRead(3'd1, rd);
      check("drain_data", rd, 8'(i));
    end
    busRead(3'd0, rd); check("drained_status", rd, 8'h04);
    busWrite(3'd0, 8'h7B);
    busRead(3'd0, rd); check("overrun_kept", rd, 8'h04);
    busWrite(3'd0, 8'h04);
    busRead(3'd0, rd); check("overrun_cleared", rd, 8'h00);

    // Stretched DATA read pops only once.
    sendByte(8'hAA, 2, acks);
    sendByte(8'hBB, 2, acks);
    CS   = 1'b1;
    WE   = 1'b0;
    addr = 3'd1;
    tick();
    check("long_read_data", DO, 8'hAA);
    repeat (3) tick();
    CS = 1'b0;
    tick();
    busRead(3'd2, rd); check("long_read_count", rd, 8'h01);
    busRead(3'd1, rd); check("long_read_next", rd, 8'hBB);
    busRead(3'd2, rd); check("long_read_empty", rd, 8'h00);

    // Push and pop together while full.
    for (int i = 0; i < 16; i++) sendByte(8'(8'h20 + i), 2, acks);
    busRead(3'd0, rd); check("prefull_status", rd, 8'h02 | 8'h01);
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    CS       = 1'b1;
    WE       = 1'b0;
    addr     = 3'd1;
    tick();
    CS = 1'b0;
    check("pushpop_data", DO, 8'h20);
    tick();
    rx_valid = 1'b0;
    tick();
    busRead(3'd0, rd); check("pushpop_status", rd, 8'h03);
    busRead(3'd2, rd); check("pushpop_count", rd, 8'h10);
    for (int i = 1; i < 16; i++) begin
      busRead(3'd1, rd);
      check("pushpop_drain", rd, 8'(8'h20 + i));
    end
    busRead(3'd1, rd); check("pushpop_last", rd, 8'h55);
    busRead(3'd0, rd); check("pushpop_end_status", rd, 8'h00);

    // Reset mid-handshake; the byte is re-accepted afterwards.
    rx_data  = 8'h99;
    rx_valid = 1'b1;
    tick();
    check("midreset_ack", {7'd0, rx_ack}, 8'h01);
    rst_n = 1'b0;
    tick();
    check("midreset_ack_low", {7'd0, rx_ack}, 8'h00);
    rst_n = 1'b1;
    tick();
    check("reaccept_ack", {7'd0, rx_ack}, 8'h01);
    rx_valid = 1'b0;
    tick();
    busRead(3'd2, rd); check("reaccept_count", rd, 8'h01);
    busRead(3'd1, rd); check("reaccept_data", rd, 8'h99);

`ifdef UART_RX_FIFO_IRQ_EN
    busWrite(3'd0, 8'h80);
    repeat (2) tick();
    check("irq_idle", {7'd0, irq}, 8'h00);
    sendByte(8'h5A, 2, acks);
    tick();
    check("irq_set", {7'd0, irq}, 8'h01);
    busRead(3'd0, rd); check("irq_status", rd, 8'h81);
    busRead(3'd1, rd); check("irq_data", rd, 8'h5A);
    tick();
    check("irq_clear", {7'd0, irq}, 8'h00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
